// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: sel codes, FSM states, grant bit indices.
// WB_DROP_R0_EN: when defined, writes to register 0 are granted but not committed.
package wb_arbiter_pkg;

    localparam logic [3:0] WB_SEL_ALU  = 4'd0;
    localparam logic [3:0] WB_SEL_LOAD = 4'd1;
    localparam logic [3:0] WB_SEL_HI   = 4'd2;
    localparam logic [3:0] WB_SEL_LO   = 4'd3;
    localparam logic [3:0] WB_SEL_EXC  = 4'd8;

    localparam int unsigned GNT_ALU  = 0;
    localparam int unsigned GNT_MD   = 1;
    localparam int unsigned GNT_LOAD = 2;
    localparam int unsigned GNT_EXC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_WRITE
    } wb_state_e;

    function automatic logic [3:0] wb_onehot(input int unsigned idx);
        logic [3:0] v;
        v = '0;
        v[idx[1:0]] = 1'b1;
        return v;
    endfunction

    function automatic logic wb_we(input logic [4:0] dest);
`ifdef WB_DROP_R0_EN
        return (dest != 5'd0);
`else
        return (dest == dest);
`endif
    endfunction

endpackage

// File: rtl/wb_arbiter_rr2.sv
// Two-way md/alu round-robin; the last-served pointer lives here and moves only on md/alu writes.
module wb_rr2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req_md,
    input  logic i_req_alu,
    input  logic i_update,
    input  logic i_served_md,
    output logic o_pick_md
);

    logic r_last_md;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last_md <= 1'b0;
        else if (i_update)
            r_last_md <= i_served_md;
    end

    // On a tie the requester not served last wins; md wins by default after reset.
    always_comb begin
        o_pick_md = i_req_md && (!i_req_alu || !r_last_md);
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: exc > load > {md, alu round-robin}, one write per two cycles.
// Optional WB_DROP_R0_EN suppresses reg_write for destination register 0.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned LOAD_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_exc,
    input  logic       req_load,
    input  logic       req_md,
    input  logic       req_alu,
    input  logic [4:0] dest_exc,
    input  logic [4:0] dest_load,
    input  logic [4:0] dest_md,
    input  logic [4:0] dest_alu,
    input  logic       md_lo,
    output logic [3:0] mux_sel,
    output logic       reg_write,
    output logic [4:0] write_reg,
    output logic [3:0] gnt,
    output logic       load_kill,
    output logic       busy
);

    wb_state_e  r_state;
    logic [2:0] r_cnt;
    logic [4:0] r_load_dest;
    logic [3:0] r_gnt;
    logic [3:0] r_sel;
    logic [4:0] r_dest;
    logic       r_reg_write;

    logic w_pick_md;
    logic w_update;
    logic w_served_md;

    always_comb begin
        w_update    = (r_state == ST_WRITE) && (r_gnt[GNT_MD] || r_gnt[GNT_ALU]);
        w_served_md = r_gnt[GNT_MD];
    end

    wb_rr2 u_rr2 (
        .clk         (clk),
        .reset       (reset),
        .i_req_md    (req_md),
        .i_req_alu   (req_alu),
        .i_update    (w_update),
        .i_served_md (w_served_md),
        .o_pick_md   (w_pick_md)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_load_dest <= '0;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_dest      <= '0;
            r_reg_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_exc) begin
                        r_state     <= ST_WRITE;
                        r_gnt       <= wb_onehot(GNT_EXC);
                        r_sel       <= WB_SEL_EXC;
                        r_dest      <= dest_exc;
                        r_reg_write <= wb_we(dest_exc);
                    end else if (req_load) begin
                        r_state     <= ST_LOAD_WAIT;
                        r_cnt       <= 3'(LOAD_WAIT - 1);
                        r_load_dest <= dest_load;
                    end else if (w_pick_md) begin
                        r_state     <= ST_WRITE;
                        r_gnt       <= wb_onehot(GNT_MD);
                        r_sel       <= md_lo ? WB_SEL_LO : WB_SEL_HI;
                        r_dest      <= dest_md;
                        r_reg_write <= wb_we(dest_md);
                    end else if (req_alu) begin
                        r_state     <= ST_WRITE;
                        r_gnt       <= wb_onehot(GNT_ALU);
                        r_sel       <= WB_SEL_ALU;
                        r_dest      <= dest_alu;
                        r_reg_write <= wb_we(dest_alu);
                    end
                end
                ST_LOAD_WAIT: begin
                    // An exception overrides the pending load; the load is never granted.
                    if (req_exc) begin
                        r_state     <= ST_WRITE;
                        r_cnt       <= '0;
                        r_gnt       <= wb_onehot(GNT_EXC);
                        r_sel       <= WB_SEL_EXC;
                        r_dest      <= dest_exc;
                        r_reg_write <= wb_we(dest_exc);
                    end else if (r_cnt == 3'd0) begin
                        r_state     <= ST_WRITE;
                        r_gnt       <= wb_onehot(GNT_LOAD);
                        r_sel       <= WB_SEL_LOAD;
                        r_dest      <= r_load_dest;
                        r_reg_write <= wb_we(r_load_dest);
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_sel       <= '0;
                    r_dest      <= '0;
                    r_reg_write <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mux_sel   = r_sel;
        reg_write = r_reg_write;
        write_reg = r_dest;
        gnt       = r_gnt;
        load_kill = (r_state == ST_LOAD_WAIT) && req_exc;
        busy      = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_wb_arbiter;

    localparam int LW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_exc, req_load, req_md, req_alu;
    logic [4:0] dest_exc, dest_load, dest_md, dest_alu;
    logic       md_lo;
    logic [3:0] mux_sel;
    logic       reg_write;
    logic [4:0] write_reg;
    logic [3:0] gnt;
    logic       load_kill;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a write slot, a countdown of remaining load-wait cycles, and who was served last.
    int       m_wait_left;
    bit       m_writing;
    bit [3:0] m_gnt;
    bit [3:0] m_sel;
    bit [4:0] m_dest;
    bit       m_rw;
    bit       m_last_md;
    bit [4:0] m_load_dest;

    always #5 clk = ~clk;

    wb_arbiter #(.LOAD_WAIT(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_exc   (req_exc),
        .req_load  (req_load),
        .req_md    (req_md),
        .req_alu   (req_alu),
        .dest_exc  (dest_exc),
        .dest_load (dest_load),
        .dest_md   (dest_md),
        .dest_alu  (dest_alu),
        .md_lo     (md_lo),
        .mux_sel   (mux_sel),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .gnt       (gnt),
        .load_kill (load_kill),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_we(input bit [4:0] d);
`ifdef WB_DROP_R0_EN
        return d != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_wait_left = 0;
        m_writing   = 0;
        m_gnt       = 0;
        m_sel       = 0;
        m_dest      = 0;
        m_rw        = 0;
        m_last_md   = 0;
        m_load_dest = 0;
    endtask

    // who: 3 exc, 2 load, 1 md, 0 alu
    task automatic start_write(input int who, input bit [4:0] d, input bit lo);
        m_writing = 1;
        m_gnt     = 4'(1 << who);
        case (who)
            3:       m_sel = 8;
            2:       m_sel = 1;
            1:       m_sel = lo ? 3 : 2;
            default: m_sel = 0;
        endcase
        m_dest = d;
        m_rw   = exp_we(d);
    endtask

    task automatic model_edge();
        if (m_writing) begin
            if (m_gnt == 4'b0010) m_last_md = 1;
            if (m_gnt == 4'b0001) m_last_md = 0;
            m_writing = 0;
            m_gnt = 0; m_sel = 0; m_dest = 0; m_rw = 0;
        end else if (m_wait_left > 0) begin
            if (req_exc) begin
                m_wait_left = 0;
                start_write(3, dest_exc, 0);
            end else begin
                m_wait_left--;
                if (m_wait_left == 0) start_write(2, m_load_dest, 0);
            end
        end else if (req_exc) begin
            start_write(3, dest_exc, 0);
        end else if (req_load) begin
            m_wait_left = LW;
            m_load_dest = dest_load;
        end else if (req_md && (!req_alu || !m_last_md)) begin
            start_write(1, dest_md, md_lo);
        end else if (req_alu) begin
            start_write(0, dest_alu, 0);
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".gnt"},       gnt,       m_gnt);
        check({ph, ".reg_write"}, reg_write, m_rw);
        check({ph, ".mux_sel"},   mux_sel,   m_sel);
        check({ph, ".write_reg"}, write_reg, m_dest);
        check({ph, ".busy"},      busy,      (m_writing || m_wait_left > 0));
    endtask

    // Inputs are already driven; check the abort indication, clock once, check registered outputs.
    task automatic cycle(input string ph);
        #1;
        check({ph, ".load_kill"}, load_kill, (m_wait_left > 0) && req_exc);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ph);
    endtask

    task automatic rand_drive();
        if (m_gnt[3]) req_exc  = 0;
        if (m_gnt[2]) req_load = 0;
        if (m_gnt[1]) req_md   = 0;
        if (m_gnt[0]) req_alu  = 0;
        if (!req_exc && $urandom_range(0, 9) == 0) begin
            req_exc = 1; dest_exc = 5'($urandom);
        end
        if (!req_load && $urandom_range(0, 3) == 0) begin
            req_load = 1; dest_load = 5'($urandom);
        end
        if (!req_md && $urandom_range(0, 2) == 0) begin
            req_md = 1; dest_md = 5'($urandom); md_lo = 1'($urandom);
        end
        if (!req_alu && $urandom_range(0, 2) == 0) begin
            req_alu = 1; dest_alu = 5'($urandom_range(0, 3));
        end
    endtask

    initial begin
        reset = 0;
        req_exc = 0; req_load = 0; req_md = 0; req_alu = 0;
        dest_exc = 0; dest_load = 0; dest_md = 0; dest_alu = 0; md_lo = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt", gnt, 4'd0);
        check("reset.reg_write", reg_write, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.load_kill", load_kill, 1'b0);
        @(negedge clk);
        reset = 1;

        // Single alu write from idle
        req_alu = 1; dest_alu = 5'd9;
        cycle("alu");
        check("alu.k_gnt", gnt, 4'b0001);
        check("alu.k_reg_write", reg_write, 1'b1);
        check("alu.k_write_reg", write_reg, 5'd9);
        check("alu.k_mux_sel", mux_sel, 4'd0);
        req_alu = 0;
        cycle("alu_idle");

        // Load with LW wait cycles
        req_load = 1; dest_load = 5'd4;
        cycle("ld_w1");
        check("ld_w1.k_busy", busy, 1'b1);
        check("ld_w1.k_reg_write", reg_write, 1'b0);
        cycle("ld_w2");
        check("ld_w2.k_busy", busy, 1'b1);
        check("ld_w2.k_reg_write", reg_write, 1'b0);
        cycle("ld_wr");
        check("ld_wr.k_gnt", gnt, 4'b0100);
        check("ld_wr.k_mux_sel", mux_sel, 4'd1);
        check("ld_wr.k_write_reg", write_reg, 5'd4);
        req_load = 0;
        cycle("ld_idle");

        // md HI write, leaving md as last served
        req_md = 1; md_lo = 0; dest_md = 5'd3;
        cycle("mdhi");
        check("mdhi.k_mux_sel", mux_sel, 4'd2);
        req_md = 0;
        cycle("mdhi_idle");

        // md and alu tied: alu first (md served last), then md LO
        req_md = 1; req_alu = 1; md_lo = 1; dest_md = 5'd7; dest_alu = 5'd8;
        cycle("rr0");
        check("rr0.k_gnt", gnt, 4'b0001);
        cycle("rr1");
        check("rr1.k_reg_write", reg_write, 1'b0);
        cycle("rr2");
        check("rr2.k_gnt", gnt, 4'b0010);
        check("rr2.k_mux_sel", mux_sel, 4'd3);
        cycle("rr3");
        cycle("rr4");
        check("rr4.k_gnt", gnt, 4'b0001);
        req_md = 0; req_alu = 0;
        cycle("rr_idle");

        // Exception aborts a waiting load
        req_load = 1; dest_load = 5'd4;
        cycle("ab_acc");
        req_exc = 1; dest_exc = 5'd31;
        #1;
        check("ab.k_load_kill", load_kill, 1'b1);
        cycle("ab_wr");
        check("ab_wr.k_gnt", gnt, 4'b1000);
        check("ab_wr.k_mux_sel", mux_sel, 4'd8);
        check("ab_wr.k_write_reg", write_reg, 5'd31);
        req_exc = 0; req_load = 0;
        cycle("ab_idle");
        cycle("ab_idle2");
        check("ab_idle2.k_busy", busy, 1'b0);

        // Reset during LOAD_WAIT
        req_load = 1; dest_load = 5'd6;
        cycle("rst_acc");
        #1 reset = 0;
        #1;
        check("rst_lw.busy", busy, 1'b0);
        check("rst_lw.gnt", gnt, 4'd0);
        check("rst_lw.reg_write", reg_write, 1'b0);
        check("rst_lw.load_kill", load_kill, 1'b0);
        model_reset();
        req_load = 0;
        #3 reset = 1;
        req_alu = 1; dest_alu = 5'd5;
        cycle("rst_alu");
        check("rst_alu.k_gnt", gnt, 4'b0001);
        check("rst_alu.k_write_reg", write_reg, 5'd5);
        req_alu = 0;

        // Reset during WRITE
        #1 reset = 0;
        #1;
        check("rst_wr.reg_write", reg_write, 1'b0);
        check("rst_wr.gnt", gnt, 4'd0);
        model_reset();
        #3 reset = 1;
        cycle("rst_wr_idle");

        // Write to register 0
        req_alu = 1; dest_alu = 5'd0;
        cycle("r0");
        check("r0.k_gnt", gnt, 4'b0001);
`ifdef WB_DROP_R0_EN
        check("r0.k_reg_write", reg_write, 1'b0);
`else
        check("r0.k_reg_write", reg_write, 1'b1);
`endif
        req_alu = 0;
        cycle("r0_idle");

        for (int i = 0; i < 400; i++) begin
            rand_drive();
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter LOAD_WAIT, default 2, SHALL set the number of wait cycles between load acceptance and its register write; legal range 1..7.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_exc, req_load, req_md, req_alu  input  1 each  SHALL be the write-back requests; each requester SHALL hold its request and dest stable until its gnt.
REQ-005 dest_exc, dest_load, dest_md, dest_alu  input  5 each  SHALL be the destination register for each requester.
REQ-006 md_lo  input  1  SHALL select LO (1) or HI (0) for an md write; sampled with req_md.
REQ-007 mux_sel  output  4  SHALL drive the memToReg selector.
REQ-008 reg_write  output  1  SHALL be the register-file write enable.
REQ-009 write_reg  output  5  SHALL be the register-file write address.
REQ-010 gnt  output  4  SHALL be the one-hot grant: bit3 exc, bit2 load, bit1 md, bit0 alu.
REQ-011 load_kill  output  1  SHALL pulse when an accepted load is aborted.
REQ-012 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, LOAD_WAIT and WRITE.
REQ-014 Fixed priority SHALL be exc > load > {md, alu}; md and alu SHALL share the lowest priority round-robin.
REQ-015 The round-robin SHALL use a 1-bit last-served pointer; on an md/alu tie the requester not served last SHALL win; the pointer SHALL update only on an md or alu WRITE.
REQ-016 IDLE with a winning exc, md or alu request SHALL go to WRITE on the next edge and latch the winner, its sel code and its dest.
REQ-017 IDLE with load winning SHALL go to LOAD_WAIT and load a counter with LOAD_WAIT-1.
REQ-018 LOAD_WAIT SHALL decrement the counter each cycle and go to WRITE when it reaches 0, giving exactly LOAD_WAIT cycles in LOAD_WAIT.
REQ-019 WRITE SHALL last exactly one cycle: reg_write=1, the winner's gnt bit=1, mux_sel and write_reg driven from latched values; then go to IDLE.
REQ-020 Sel codes SHALL be: alu 4'd0, load 4'd1, md HI 4'd2, md LO 4'd3, exc 4'd8.
REQ-021 req_exc during LOAD_WAIT SHALL abort the load: load_kill=1 for one cycle, no load write, then WRITE for exc on the next edge.
REQ-022 An aborted load SHALL NOT receive gnt; the load requester SHALL re-request if still required.
REQ-023 Outside WRITE: reg_write=0, gnt=0, mux_sel=4'd0 and write_reg=5'd0.
REQ-024 Back-to-back requests SHALL yield at most one write every two cycles (WRITE always returns to IDLE).
REQ-025 No request SHALL be sampled while in WRITE or LOAD_WAIT, except req_exc in LOAD_WAIT.

Reset
REQ-026 reset low SHALL immediately force IDLE, counter 0, round-robin pointer to alu-last, and all outputs to 0, including mid-WRITE and mid-LOAD_WAIT.
REQ-027 A load in flight at reset SHALL be discarded silently, with no load_kill pulse.

Configuration
REQ-028 With WB_DROP_R0_EN defined, a WRITE whose latched dest is 5'd0 SHALL assert gnt but hold reg_write=0.
REQ-029 Without WB_DROP_R0_EN, writes to register 0 SHALL assert reg_write like any other write.

Structure
REQ-030 A shared package SHALL hold the sel-code constants (WB_SEL_ALU, WB_SEL_LOAD, WB_SEL_HI, WB_SEL_LO, WB_SEL_EXC), the state encoding and the gnt bit indices.
REQ-031 The md/alu round-robin SHALL be one sub-module, wb_rr2, with the pointer register inside it.

Verification
REQ-032 Bench: req_alu=1, dest_alu=5'd9 in IDLE -> next cycle WRITE: reg_write=1, mux_sel=0, write_reg=9, gnt=4'b0001.
REQ-033 Bench: req_load=1, dest=5'd4, LOAD_WAIT=2 -> 2 cycles busy with reg_write=0, then WRITE with mux_sel=1, write_reg=4, gnt=4'b0100.
REQ-034 Bench: req_md and req_alu held high together, md_lo=1 -> writes alternate alu(sel 0) then md(sel 3), each one cycle apart from IDLE.
REQ-035 Bench: req_exc asserted during the first LOAD_WAIT cycle with dest_exc=31 -> load_kill pulse, then WRITE with mux_sel=8, write_reg=31, gnt=4'b1000; no load write.
REQ-036 Bench: reset low during LOAD_WAIT -> outputs 0 and busy=0 asynchronously; after release, an alu request is granted normally.
REQ-037 Bench: with WB_DROP_R0_EN, req_alu with dest_alu=0 -> gnt=4'b0001 with reg_write=0; without the macro, reg_write=1.
